// File: rtl/adc_sample_reader.sv
// adc_sample_reader: drives a 3-wire serial ADC and hands each sample to the consumer over valid/ready.
// Define ADC_AVG_EN to run four back-to-back conversions per request and output their truncated average.
module adc_sample_reader #(
    parameter int DATA_W      = 16,
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_sdo,
    output logic [DATA_W-1:0] adc_data,
    output logic              data_valid,
    input  logic              data_ready
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(DATA_W - 1);

`ifdef ADC_AVG_EN
    typedef enum logic [2:0] {IDLE, CONVERT, SHIFT, DONE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;
`endif

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [CONV_W-1:0] conv_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;

`ifdef ADC_AVG_EN
    logic [1:0]        conv_idx;
    logic [DATA_W+1:0] acc;
    logic [DATA_W+1:0] acc_sum;

    // The final sample is complete in shift_reg by the end of the last high phase.
    assign acc_sum = acc + {2'b00, shift_reg};
`endif

    always_ff @(posedge clk) begin
        // NOTE: control and datapath registers are all cleared here so a reset mid-frame leaves no stale partial sample behind.
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            adc_data   <= '0;
            data_valid <= 1'b0;
            div_cnt    <= '0;
            conv_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
`ifdef ADC_AVG_EN
            conv_idx   <= '0;
            acc        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the previous-cycle register values.
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CONVERT;
                        busy     <= 1'b1;
                        adc_cs_n <= 1'b0;
                        conv_cnt <= '0;
`ifdef ADC_AVG_EN
                        conv_idx <= '0;
                        acc      <= '0;
`endif
                    end
                end

                CONVERT: begin
                    if (conv_cnt == CONV_LAST) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= BIT_FIRST;
                    end else begin
                        conv_cnt <= conv_cnt + CONV_W'(1);
                    end
                end

                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!adc_sclk) begin
                            // Data is sampled on the same clk edge that raises sclk.
                            adc_sclk  <= 1'b1;
                            shift_reg <= {shift_reg[DATA_W-2:0], adc_sdo};
                        end else begin
                            adc_sclk <= 1'b0;
                            if (bit_cnt != '0) begin
                                bit_cnt <= bit_cnt - BIT_W'(1);
                            end else begin
                                adc_cs_n <= 1'b1;
`ifdef ADC_AVG_EN
                                acc <= acc_sum;
                                if (conv_idx == 2'd3) begin
                                    adc_data   <= acc_sum[DATA_W+1:2];
                                    data_valid <= 1'b1;
                                    state      <= DONE;
                                end else begin
                                    conv_idx <= conv_idx + 2'd1;
                                    state    <= GAP;
                                end
`else
                                adc_data   <= shift_reg;
                                data_valid <= 1'b1;
                                state      <= DONE;
`endif
                            end
                        end
                    end
                end

`ifdef ADC_AVG_EN
                GAP: begin
                    adc_cs_n <= 1'b0;
                    conv_cnt <= '0;
                    state    <= CONVERT;
                end
`endif

                DONE: begin
                    if (data_ready) begin
                        state      <= IDLE;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_reader.sv
// Scoreboard bench for adc_sample_reader: a default instance and a fast one (CLK_DIV=1, CONV_CYCLES=1).
// Build with ADC_AVG_EN defined to exercise the four-conversion averaging variant.
`timescale 1ns/1ps
module tb_adc_sample_reader;

    localparam int DW    = 16;
    localparam int NI    = 2;
    localparam int CD_P [NI] = '{4, 1};
    localparam int CV_P [NI] = '{8, 1};
`ifdef ADC_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif
    localparam int LIMIT = 5000;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset [NI];
    logic          start [NI];
    logic          busy  [NI];
    logic          cs_n  [NI];
    logic          sclk  [NI];
    logic          sdo   [NI];
    logic [DW-1:0] data  [NI];
    logic          valid [NI];
    logic          ready [NI];

    logic [DW-1:0] samp_q [NI][$];
    exp_t          exp_q  [NI][$];
    int            rises  [NI];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Start-to-first-valid latency: each conversion is the CONV wait plus DW sclk periods,
    // separated by one-cycle gaps, plus the acceptance cycle. Defaults give 137.
    function automatic int exp_latency(int g);
        return 1 + NCONV * (CV_P[g] + 2 * CD_P[g] * DW) + (NCONV - 1);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic flag(string name, string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    for (genvar g = 0; g < NI; g++) begin : gen_inst
        adc_sample_reader #(
            .DATA_W     (DW),
            .CLK_DIV    (CD_P[g]),
            .CONV_CYCLES(CV_P[g])
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .start     (start[g]),
            .busy      (busy[g]),
            .adc_cs_n  (cs_n[g]),
            .adc_sclk  (sclk[g]),
            .adc_sdo   (sdo[g]),
            .adc_data  (data[g]),
            .data_valid(valid[g]),
            .data_ready(ready[g])
        );

        // ADC model: a new frame per chip-select assertion, MSB first, next bit after each sclk rise.
        int            idx      = DW - 1;
        logic          active   = 1'b0;
        logic          psclk_m  = 1'b0;
        logic [DW-1:0] frame    = '0;

        always @(negedge clk) begin
            if (cs_n[g] !== 1'b0) begin
                active = 1'b0;
                idx    = DW - 1;
                sdo[g] = 1'($urandom);
            end else begin
                if (!active) begin
                    active = 1'b1;
                    idx    = DW - 1;
                    if (samp_q[g].size() > 0) frame = samp_q[g].pop_front();
                    else                      frame = DW'($urandom);
                end else if (sclk[g] && !psclk_m && idx > 0) begin
                    idx--;
                end
                sdo[g] = frame[idx];
            end
            psclk_m = sclk[g];
        end

        // Monitor: looks just after the falling edge, when inputs hold what the next rising edge samples.
        int            gaps   = 0;
        int            hi_run = 0;
        logic          pv     = 1'b0;
        logic          pready = 1'b0;
        logic          phand  = 1'b0;
        logic          psclk  = 1'b0;
        logic [DW-1:0] pdata  = '0;
        exp_t          e;

        always begin
            @(negedge clk);
            #1;
            if (reset[g] === 1'b1) begin
                rises[g] = 0;
                gaps     = 0;
                hi_run   = 0;
                phand    = 1'b0;
            end else begin
                if (phand) begin
                    check($sformatf("i%0d busy_after_take", g), busy[g], 0);
                    check($sformatf("i%0d valid_after_take", g), valid[g], 0);
                end
                if (pv && !pready) begin
                    check($sformatf("i%0d hold_valid", g), valid[g], 1);
                    check($sformatf("i%0d hold_data", g), data[g], pdata);
                end
                if (sclk[g] && !psclk && !cs_n[g]) rises[g]++;
                if (cs_n[g] && busy[g] && !valid[g]) begin
                    hi_run++;
                end else if (!cs_n[g] && hi_run > 0) begin
                    check($sformatf("i%0d gap_len", g), hi_run, 1);
                    gaps++;
                    hi_run = 0;
                end
                if (valid[g] && !pv) begin
                    if (exp_q[g].size() == 0) begin
                        flag($sformatf("i%0d unexpected_valid", g),
                             $sformatf("actual data %0h required no valid", data[g]));
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("i%0d data", g), data[g], e.data);
                        check($sformatf("i%0d latency", g), cyc - e.cyc, exp_latency(g));
                        check($sformatf("i%0d sclk_rises", g), rises[g], NCONV * DW);
                        check($sformatf("i%0d gaps", g), gaps, NCONV - 1);
                    end
                    rises[g] = 0;
                    gaps     = 0;
                end
                phand = valid[g] && ready[g];
            end
            pv     = valid[g];
            pready = ready[g];
            pdata  = data[g];
            psclk  = sclk[g];
        end
    end

    // Issue one request; the reference result is the plain truncated mean of the samples it consumes.
    task automatic request(int g, logic [DW-1:0] s0, logic [DW-1:0] s1,
                           logic [DW-1:0] s2, logic [DW-1:0] s3);
        logic [DW-1:0] s [4];
        int            sum;
        exp_t          x;
        s   = '{s0, s1, s2, s3};
        sum = 0;
        for (int k = 0; k < NCONV; k++) begin
            samp_q[g].push_back(s[k]);
            sum += int'(s[k]);
        end
        x.data = DW'(sum / NCONV);
        x.cyc  = cyc;
        exp_q[g].push_back(x);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic pulse_start(int g);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_idle(int g, string name);
        int n = 0;
        while ((busy[g] !== 1'b0 || valid[g] !== 1'b0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) flag(name, $sformatf("actual still busy after %0d cycles required idle", LIMIT));
    endtask

    task automatic wait_valid(int g, string name);
        int n = 0;
        while (valid[g] !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) flag(name, $sformatf("actual no valid after %0d cycles required valid", LIMIT));
    endtask

    initial begin
        int            n;
        int            nr;
        logic          prev;
        logic [DW-1:0] r [4];

        for (int g = 0; g < NI; g++) begin
            reset[g] = 1'b1;
            start[g] = 1'b0;
            ready[g] = 1'b0;
            rises[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("i%0d rst_busy", g), busy[g], 0);
            check($sformatf("i%0d rst_cs_n", g), cs_n[g], 1);
            check($sformatf("i%0d rst_sclk", g), sclk[g], 0);
            check($sformatf("i%0d rst_data", g), data[g], 0);
            check($sformatf("i%0d rst_valid", g), valid[g], 0);
            reset[g] = 1'b0;
        end
        @(negedge clk);

        // Basic frame with immediate acceptance.
        ready[0] = 1'b1;
        request(0, 16'h3081, 16'h3081, 16'h3081, 16'h3081);
        wait_idle(0, "t1_done");

        // Back-pressure: sample must hold for 50 cycles.
        ready[0] = 1'b0;
        request(0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        wait_valid(0, "t2_valid");
        repeat (50) @(negedge clk);
        ready[0] = 1'b1;
        wait_idle(0, "t2_done");

        // Starts during CONVERT and SHIFT are dropped.
        request(0, 16'h5A3C, 16'h5A3C, 16'h5A3C, 16'h5A3C);
        repeat (2) @(negedge clk);
        pulse_start(0);
        n = 0;
        while (sclk[0] !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        pulse_start(0);
        wait_idle(0, "t3_done");
        repeat (3) @(negedge clk);
        check("t3 no_queued_start", busy[0], 0);

        // Reset after the 7th sclk rise discards the frame.
        for (int k = 0; k < NCONV; k++) samp_q[0].push_back(16'hC3C3);
        pulse_start(0);
        nr   = 0;
        n    = 0;
        prev = sclk[0];
        while (nr < 7 && n < LIMIT) begin
            @(negedge clk);
            if (sclk[0] && !prev) nr++;
            prev = sclk[0];
            n++;
        end
        reset[0] = 1'b1;
        @(negedge clk);
        check("t4 cs_n", cs_n[0], 1);
        check("t4 sclk", sclk[0], 0);
        check("t4 busy", busy[0], 0);
        check("t4 data", data[0], 0);
        check("t4 valid", valid[0], 0);
        reset[0] = 1'b0;
        samp_q[0].delete();
        @(negedge clk);
        request(0, 16'h1E5B, 16'h1E5B, 16'h1E5B, 16'h1E5B);
        wait_idle(0, "t4_done");

        // Start in the same cycle DONE hands off is ignored.
        ready[0] = 1'b0;
        request(0, 16'h6DB6, 16'h6DB6, 16'h6DB6, 16'h6DB6);
        wait_valid(0, "t5_valid");
        @(negedge clk);
        ready[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        check("t5 start_in_done_ignored", busy[0], 0);

        // Fast instance: all-ones then all-zeros.
        ready[1] = 1'b1;
        request(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_idle(1, "t6_ones");
        request(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_idle(1, "t6_zeros");

        // Averaging pattern (sum 0x29, mean 0x000A when averaging; first sample otherwise).
        request(0, 16'h0004, 16'h0008, 16'h000C, 16'h0011);
        wait_idle(0, "t7_done");

        // Random samples with random consumer stalls on both instances.
        for (int k = 0; k < 8; k++) begin
            int g;
            g = k % NI;
            for (int j = 0; j < 4; j++) r[j] = DW'($urandom);
            ready[g] = 1'b0;
            request(g, r[0], r[1], r[2], r[3]);
            wait_valid(g, $sformatf("rand%0d_valid", k));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            ready[g] = 1'b1;
            wait_idle(g, $sformatf("rand%0d_done", k));
        end

        repeat (5) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("i%0d pending_results", g), exp_q[g].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
